// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial adder controller
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational 2-bit ripple-carry slice (two chained full adders)
module adder_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic w_c1;

  assign s[0] = a[0] ^ b[0] ^ cin;
  assign w_c1 = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
  assign s[1] = a[1] ^ b[1] ^ w_c1;
  assign cout = (a[1] & b[1]) | (a[1] & w_c1) | (b[1] & w_c1);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - WIDTH-bit adder computed two bits per cycle through one shared slice
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NSTEP = WIDTH / SLICE_W;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH+1:0] w_sum_ext;

  adder_slice u_slice (
    .a    (r_a_sh[1:0]),
    .b    (r_b_sh[1:0]),
    .cin  (r_carry),
    .s    (w_slice_sum),
    .cout (w_slice_cout)
  );

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_last_step = (r_cnt == CNT_W'(NSTEP - 1));
  // New slice bits enter at the top; the dropped low 2 bits fall off the extended vector.
  assign w_sum_ext   = {w_slice_sum, r_sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_state_nxt = RUN;
      RUN:     if (w_last_step) w_state_nxt = DONE;
      DONE:    if (out_ready)   w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == RUN) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> SLICE_W;
      r_b_sh   <= r_b_sh >> SLICE_W;
      r_sum_sh <= w_sum_ext[WIDTH+1:2];
      r_carry  <= w_slice_cout;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign sum   = r_sum_sh;
  assign c_out = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       c_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Call on a negedge; leaves the bench on a negedge after the result is consumed.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [7:0] es, input logic ec, input string nm);
    int w;
    int edges;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk({nm, "_latency"}, 32'(edges), 32'd4);
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(c_out), 32'(ec));
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] model;
    logic [7:0] hold_sum;
    logic       hold_cout;
    logic       seen_ov;
    int         cyc;
    int         acc_cyc[$];
    logic [8:0] res[$];

    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
    vecs.push_back('{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp_sum, vecs[i].exp_cout,
             $sformatf("vec%0d", i));

    // Carry must stay set after every step of 0xFF + 0x01.
    a = 8'hFF; b = 8'h01; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("carry_step%0d", s), 32'(c_out), 32'd1);
    end
    chk("carry_done_valid", 32'(out_valid), 32'd1);
    chk("carry_done_sum", 32'(sum), 32'h00);
    @(negedge clk);

    // Backpressure in DONE with an ignored in_valid pulse.
    a = 8'hC3; b = 8'h2A; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_valid0", 32'(out_valid), 32'd1);
    chk("bp_sum0", 32'(sum), 32'hEE);
    hold_sum = sum; hold_cout = c_out;
    for (int k = 0; k < 5; k++) begin
      a = 8'h11; b = 8'h22; c_in = 1'b0; in_valid = (k % 2 == 0);
      @(negedge clk);
      chk($sformatf("bp_valid_c%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ready_c%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp_stable_c%0d", k), 32'({hold_cout, hold_sum}), 32'({c_out, sum}));
    end
    chk("bp_cout", 32'(c_out), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    run_op(8'h40, 8'h05, 1'b0, 8'h45, 1'b0, "bp_fresh");

    // Asynchronous reset in the middle of RUN.
    a = 8'hAB; b = 8'h11; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(c_out), 32'd0);
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    seen_ov = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen_ov = seen_ov | out_valid;
    end
    chk("arst_no_result", 32'(seen_ov), 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "arst_next");

    // Back-to-back with in_valid and out_ready held high.
    a = 8'h80; b = 8'h80; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (cyc < 40 && res.size() < 2) begin
      if (out_valid) res.push_back({c_out, sum});
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        if (acc_cyc.size() == 1) begin
          @(negedge clk);
          cyc++;
          a = 8'h01; b = 8'h02;
          continue;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
    chk("b2b_results", 32'(res.size()), 32'd2);
    if (acc_cyc.size() == 2) chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    if (res.size() == 2) begin
      chk("b2b_res0", 32'(res[0]), 32'h100);
      chk("b2b_res1", 32'(res[1]), 32'h003);
    end
    repeat (2) @(negedge clk);

    for (int r = 0; r < 20; r++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = 9'(int'(ra) + int'(rb) + int'(rc));
      run_op(ra, rb, rc, model[7:0], model[8], $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
